crc_stream_feeder: RTL and testbench
====================================

Name: crc_stream_feeder

Overview:
- Upstream bus-master stage for the memory-mapped CRC block at BASE_ADDR.
- Accepts a start command carrying ctrl, poly and seed words, plus a byte stream with valid/ready/last.
- Programs the CRC registers, packs bytes MSB-first into 32-bit words, and writes each word to the DATA register.
- Reads back the final CRC and presents it with a one-cycle done pulse.

Parameters:
- BASE_ADDR, 32'h4003_2000, CRC register base; DATA=+0, GPOLY=+4, CTRL=+8.
- CNT_W, 16, width of the data-word counter.
- TIMEOUT_CYC, 1024, stall limit in cycles; used only with the optional feature.

Ports:
- clk in 1: clock.
- rst in 1: reset, asynchronous, active-high.
- start in 1: begin a job; sampled in IDLE only.
- cfg_ctrl in 32: CTRL value for the job (TOT/TOTR/FXOR/TCRC fields).
- cfg_poly in 32: polynomial.
- cfg_seed in 32: seed.
- s_data in 8: stream byte.
- s_valid in 1: byte valid.
- s_last in 1: final byte of the job.
- s_ready out 1: byte accepted when s_valid && s_ready.
- addr out 32: bus address.
- data_wr out 32: bus write data.
- RW out 1: 1 = write, 0 = read.
- Sel out 1: bus select.
- data_rd in 32: bus read data, combinational from the CRC block.
- busy out 1: job in progress.
- done out 1: one-cycle pulse when crc_result is valid.
- crc_result out 32: captured CRC, held until the next done.
- word_count out CNT_W: DATA writes issued in the current or last job.
- pad_bytes out 2: zero bytes appended to the final word.
- timeout_err out 1: sticky stall abort flag.

Behaviour:
- Reset (async):
  - State IDLE.
  - Outputs addr=0, data_wr=0, RW=0, Sel=0, s_ready=0, busy=0, done=0, crc_result=0, word_count=0, pad_bytes=0, timeout_err=0.
  - Packing register and byte index cleared.
- All bus outputs are registered. One bus access per cycle with Sel=1; Sel=0 in every other cycle.
- FSM: IDLE -> WR_CTRL_S -> WR_SEED -> WR_POLY -> WR_CTRL_R -> STREAM <-> WR_DATA -> RD_RES -> IDLE.
- IDLE:
  - start=1 captures the cfg_* inputs, clears word_count, pad_bytes and timeout_err, sets busy=1, and moves to WR_CTRL_S.
  - start in any other state is ignored.
- WR_CTRL_S: addr=BASE+8, data_wr = cfg_ctrl | 32'h0200_0000 (WAS=1), RW=1.
- WR_SEED: addr=BASE, data_wr=cfg_seed, RW=1.
- WR_POLY: addr=BASE+4, data_wr=cfg_poly, RW=1.
- WR_CTRL_R: addr=BASE+8, data_wr = cfg_ctrl & ~32'h0200_0000, RW=1.
- STREAM:
  - s_ready=1. Each accepted byte goes to lane 3-idx (idx 0 lands in bits 31:24), then idx increments.
  - On acceptance with idx==3 or s_last=1, the next state is WR_DATA.
  - If s_last arrives with idx<3, the remaining lanes are zero and pad_bytes = 3-idx.
- WR_DATA:
  - addr=BASE, data_wr=packed word, RW=1, s_ready=0; word_count increments; idx clears.
  - Next state is RD_RES if the word held last, else STREAM.
- RD_RES:
  - addr=BASE, RW=0, Sel=1.
  - data_rd is captured into crc_result at the end of this cycle. The DATA write's effect is registered by then.
  - done=1 in the following cycle, busy=0, return to IDLE.
- Latency:
  - First s_ready is asserted 5 cycles after start is sampled.
  - Steady throughput is 4 bytes per 5 cycles.
  - done follows the last-word write by 2 cycles.
- word_count saturates at its all-ones value; the job continues.
- Reset mid-job aborts immediately: Sel drops asynchronously, no done, and crc_result keeps 0.

Optional Feature:
- Macro CRC_FEEDER_TIMEOUT_EN.
- Defined:
  - A stall counter runs in STREAM while s_valid=0 and resets on any accepted byte.
  - At TIMEOUT_CYC the block sets timeout_err=1, discards the partial word, skips RD_RES and returns to IDLE with busy=0 and no done pulse.
- Undefined: no counter; timeout_err tied 0; STREAM waits indefinitely.

Test Plan:
- Sequence check:
  - Stimulus: start with ctrl=32'h0000_0000, poly=32'h0000_1021, seed=32'h0000_FFFF.
  - Required bus writes, in order: (4003_2008, 0200_0000), (4003_2000, 0000_FFFF), (4003_2004, 0000_1021), (4003_2008, 0000_0000).
- Full-word packing:
  - Stimulus: bytes 31,32,33,34 with last on 34.
  - Required: one write (4003_2000, 3132_3334), then a read; word_count=1, pad_bytes=0.
  - Required: with a bus model returning 0000_ABCD, done pulses and crc_result=0000_ABCD.
- Padding:
  - Stimulus: bytes 31..39 (9 bytes).
  - Required: writes 3132_3334, 3536_3738, 3900_0000; word_count=3, pad_bytes=3.
- Backpressure:
  - Stimulus: s_valid toggled every other cycle.
  - Required: no byte lost or duplicated; s_ready=0 in every WR_DATA cycle.
- Reset and start-while-busy:
  - Stimulus: rst asserted during STREAM.
  - Required: Sel=0 and busy=0 immediately, no done.
  - Stimulus: start pulsed during STREAM.
  - Required: cfg unchanged, no restart.
- Timeout (CRC_FEEDER_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Stimulus: 2 bytes, then s_valid=0 for 16 cycles.
  - Required: timeout_err=1, busy=0, no DATA write, no done.

Source files
------------

// File: rtl/crc_stream_feeder.sv
// crc_stream_feeder
//
// Bus-master front end for a memory-mapped CRC block located at BASE_ADDR.
// A job starts with a start pulse carrying ctrl/poly/seed words. The block
// programs the CRC registers, then packs an incoming byte stream MSB-first
// into 32-bit words and writes each word to the DATA register. After the
// final word it reads DATA back, captures the CRC and pulses done.
//
// Register map (offsets from BASE_ADDR): DATA=+0, GPOLY=+4, CTRL=+8.
// Bus sequence per job:
//   CTRL (WAS=1), DATA (seed), GPOLY (poly), CTRL (WAS=0),
//   then { DATA (packed word) } per 4 bytes, then one DATA read.
//
// Optional feature macro: CRC_FEEDER_TIMEOUT_EN
//   When defined, a stall of TIMEOUT_CYC cycles without s_valid while in
//   STREAM aborts the job, sets timeout_err and skips the read-back.
//   When undefined, STREAM waits indefinitely and timeout_err is tied 0.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             begin a job (sampled in IDLE only)
//   cfg_ctrl/poly/seed  job configuration words
//   s_data/s_valid/s_last/s_ready  byte stream, accepted on valid && ready
//   addr/data_wr/RW/Sel  registered bus master outputs (RW=1 write)
//   data_rd           combinational read data from the CRC block
//   busy              job in progress
//   done              one-cycle pulse when crc_result is updated
//   crc_result        captured CRC, held until the next done
//   word_count        DATA writes issued in the current/last job (saturating)
//   pad_bytes         zero bytes appended to the final word
//   timeout_err       sticky stall-abort flag (cleared by start)

module crc_stream_feeder #(
  parameter logic [31:0] BASE_ADDR   = 32'h4003_2000,
  parameter int          CNT_W       = 16,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      cfg_ctrl,
  input  logic [31:0]      cfg_poly,
  input  logic [31:0]      cfg_seed,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [31:0]      addr,
  output logic [31:0]      data_wr,
  output logic             RW,
  output logic             Sel,
  input  logic [31:0]      data_rd,
  output logic             busy,
  output logic             done,
  output logic [31:0]      crc_result,
  output logic [CNT_W-1:0] word_count,
  output logic [1:0]       pad_bytes,
  output logic             timeout_err
);

  localparam logic [31:0] ADDR_DATA = BASE_ADDR;
  localparam logic [31:0] ADDR_POLY = BASE_ADDR + 32'd4;
  localparam logic [31:0] ADDR_CTRL = BASE_ADDR + 32'd8;
  localparam logic [31:0] WAS_BIT   = 32'h0200_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CTRL_S,
    ST_WR_SEED,
    ST_WR_POLY,
    ST_WR_CTRL_R,
    ST_STREAM,
    ST_WR_DATA,
    ST_RD_RES
  } state_t;

  state_t state_q, state_d;

  // Captured job configuration
  logic [31:0] ctrl_q, poly_q, seed_q;

  // Packing state
  logic [31:0] pack_q;
  logic [1:0]  idx_q;
  logic        last_q;

  // Registered outputs and their next values
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_wr_q, data_wr_d;
  logic             rw_q, rw_d;
  logic             sel_q, sel_d;
  logic             s_ready_q, s_ready_d;
  logic             busy_q;
  logic             done_q;
  logic [31:0]      crc_q;
  logic [CNT_W-1:0] word_count_q;
  logic [1:0]       pad_q;

  logic        byte_acc;
  logic        word_end;
  logic        timeout_hit;
  logic [31:0] packed_word;
  logic [31:0] ctrl_eff;

  // s_ready is high for exactly the STREAM cycles, so acceptance only
  // needs the state and s_valid.
  assign byte_acc = (state_q == ST_STREAM) && s_valid;
  assign word_end = byte_acc && ((idx_q == 2'd3) || s_last);

  // Current word with the byte being accepted merged into lane 3-idx.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign packed_word[8*gi +: 8] =
        (byte_acc && (idx_q == 2'(3 - gi))) ? s_data : pack_q[8*gi +: 8];
    end
  endgenerate

  // The first CTRL write is launched on the same edge that captures the
  // configuration, so it must take the value straight from the input.
  assign ctrl_eff = (state_q == ST_IDLE) ? cfg_ctrl : ctrl_q;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_WR_CTRL_S;
      ST_WR_CTRL_S: state_d = ST_WR_SEED;
      ST_WR_SEED:   state_d = ST_WR_POLY;
      ST_WR_POLY:   state_d = ST_WR_CTRL_R;
      ST_WR_CTRL_R: state_d = ST_STREAM;
      ST_STREAM: begin
        if (timeout_hit) begin
          state_d = ST_IDLE;
        end else if (word_end) begin
          state_d = ST_WR_DATA;
        end
      end
      ST_WR_DATA:   state_d = last_q ? ST_RD_RES : ST_STREAM;
      ST_RD_RES:    state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: output logic. Decoded from the next state so that the registered
  // bus outputs line up with the state they belong to.
  // ---------------------------------------------------------------------
  always_comb begin
    addr_d    = 32'h0;
    data_wr_d = 32'h0;
    rw_d      = 1'b0;
    sel_d     = 1'b0;
    s_ready_d = 1'b0;
    case (state_d)
      ST_WR_CTRL_S: begin
        addr_d    = ADDR_CTRL;
        data_wr_d = ctrl_eff | WAS_BIT;
        rw_d      = 1'b1;
        sel_d     = 1'b1;
      end
      ST_WR_SEED: begin
        addr_d    = ADDR_DATA;
        data_wr_d = seed_q;
        rw_d      = 1'b1;
        sel_d     = 1'b1;
      end
      ST_WR_POLY: begin
        addr_d    = ADDR_POLY;
        data_wr_d = poly_q;
        rw_d      = 1'b1;
        sel_d     = 1'b1;
      end
      ST_WR_CTRL_R: begin
        addr_d    = ADDR_CTRL;
        data_wr_d = ctrl_q & ~WAS_BIT;
        rw_d      = 1'b1;
        sel_d     = 1'b1;
      end
      ST_STREAM: begin
        s_ready_d = 1'b1;
      end
      ST_WR_DATA: begin
        addr_d    = ADDR_DATA;
        data_wr_d = packed_word;
        rw_d      = 1'b1;
        sel_d     = 1'b1;
      end
      ST_RD_RES: begin
        addr_d = ADDR_DATA;
        sel_d  = 1'b1;
      end
      default: begin
        addr_d = 32'h0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= 32'h0;
      data_wr_q    <= 32'h0;
      rw_q         <= 1'b0;
      sel_q        <= 1'b0;
      s_ready_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      crc_q        <= 32'h0;
      word_count_q <= '0;
      pad_q        <= 2'd0;
      ctrl_q       <= 32'h0;
      poly_q       <= 32'h0;
      seed_q       <= 32'h0;
      pack_q       <= 32'h0;
      idx_q        <= 2'd0;
      last_q       <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      data_wr_q <= data_wr_d;
      rw_q      <= rw_d;
      sel_q     <= sel_d;
      s_ready_q <= s_ready_d;
      done_q    <= (state_q == ST_RD_RES);

      if ((state_q == ST_IDLE) && start) begin
        ctrl_q       <= cfg_ctrl;
        poly_q       <= cfg_poly;
        seed_q       <= cfg_seed;
        busy_q       <= 1'b1;
        word_count_q <= '0;
        pad_q        <= 2'd0;
        pack_q       <= 32'h0;
        idx_q        <= 2'd0;
        last_q       <= 1'b0;
      end

      if (byte_acc) begin
        pack_q <= packed_word;
        idx_q  <= idx_q + 2'd1;
        if (s_last) begin
          last_q <= 1'b1;
          // unfilled lanes are already zero in pack_q
          pad_q  <= 2'd3 - idx_q;
        end
        // count the DATA write as it is launched; hold at all-ones
        if (word_end && (word_count_q != '1)) begin
          word_count_q <= word_count_q + CNT_W'(1);
        end
      end

      if (state_q == ST_WR_DATA) begin
        pack_q <= 32'h0;
        idx_q  <= 2'd0;
      end

      if (state_q == ST_RD_RES) begin
        crc_q  <= data_rd;
        busy_q <= 1'b0;
      end

      if (timeout_hit) begin
        busy_q <= 1'b0;
        pack_q <= 32'h0;
        idx_q  <= 2'd0;
      end
    end
  end

`ifdef CRC_FEEDER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYC + 1);

  logic [STALL_W-1:0] stall_q;
  logic               terr_q;

  // Fires on the TIMEOUT_CYC-th consecutive idle STREAM cycle.
  assign timeout_hit = (state_q == ST_STREAM) && !s_valid &&
                       (stall_q == STALL_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      if ((state_q == ST_STREAM) && !s_valid) begin
        stall_q <= stall_q + STALL_W'(1);
      end else begin
        stall_q <= '0;
      end

      if ((state_q == ST_IDLE) && start) begin
        terr_q <= 1'b0;
      end else if (timeout_hit) begin
        terr_q <= 1'b1;
      end
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign addr       = addr_q;
  assign data_wr    = data_wr_q;
  assign RW         = rw_q;
  assign Sel        = sel_q;
  assign s_ready    = s_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign crc_result = crc_q;
  assign word_count = word_count_q;
  assign pad_bytes  = pad_q;

endmodule

// File: tb/tb_crc_stream_feeder.sv
// Self-checking bench for crc_stream_feeder: directed and randomized jobs
// compared against a word-level model of the expected bus traffic.
module tb_crc_stream_feeder;

  localparam logic [31:0] BASE   = 32'h4003_2000;
  localparam logic [31:0] WAS    = 32'h0200_0000;
  localparam int          CW     = 2;
  localparam int          WC_MAX = (1 << CW) - 1;
`ifdef CRC_FEEDER_TIMEOUT_EN
  localparam int          TO     = 16;
`else
  localparam int          TO     = 1024;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [31:0]   cfg_ctrl, cfg_poly, cfg_seed;
  logic [7:0]    s_data;
  logic          s_valid, s_last, s_ready;
  logic [31:0]   addr, data_wr, data_rd;
  logic          RW, Sel, busy, done;
  logic [31:0]   crc_result;
  logic [CW-1:0] word_count;
  logic [1:0]    pad_bytes;
  logic          timeout_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [64:0] bus_log[$];   // {addr, data_wr, RW} per Sel cycle
  int          done_cnt    = 0;
  int          last_wr_cyc = 0;
  int          rdy_in_wr   = 0;
  logic [7:0]  bytes_q[$];

  crc_stream_feeder #(
    .BASE_ADDR  (BASE),
    .CNT_W      (CW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cfg_ctrl   (cfg_ctrl),
    .cfg_poly   (cfg_poly),
    .cfg_seed   (cfg_seed),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .addr       (addr),
    .data_wr    (data_wr),
    .RW         (RW),
    .Sel        (Sel),
    .data_rd    (data_rd),
    .busy       (busy),
    .done       (done),
    .crc_result (crc_result),
    .word_count (word_count),
    .pad_bytes  (pad_bytes),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (Sel) bus_log.push_back({addr, data_wr, RW});
    if (Sel && RW && (addr == BASE)) begin
      last_wr_cyc <= cyc;
      if (s_ready) rdy_in_wr <= rdy_in_wr + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq(input logic [7:0] first, input int n);
    logic [7:0] b;
    bytes_q.delete();
    b = first;
    for (int i = 0; i < n; i++) begin
      bytes_q.push_back(b);
      b = b + 8'd1;
    end
  endtask

  task automatic fill_rand(input int n);
    bytes_q.delete();
    for (int i = 0; i < n; i++) bytes_q.push_back(8'($urandom));
  endtask

  // gap_mode: 0 back-to-back, 1 s_valid toggling, 2 random idle gaps
  task automatic run_job(input logic [31:0] ctrl, input logic [31:0] poly,
                         input logic [31:0] seed, input logic [31:0] rdv,
                         input int gap_mode, input bit poke_start);
    int n, lb, db, rb, c0, g, nw, npad, done_at, gaps;
    bit stuck;
    logic [31:0] w;
    logic [64:0] e;
    n = bytes_q.size(); lb = bus_log.size(); db = done_cnt; rb = rdy_in_wr;
    stuck = 1'b0;

    @(negedge clk);
    cfg_ctrl = ctrl; cfg_poly = poly; cfg_seed = seed; data_rd = rdv;
    start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    // change cfg inputs after start so that capture is really checked
    cfg_ctrl = $urandom; cfg_poly = $urandom; cfg_seed = $urandom;
    g = 1;
    while (!s_ready && g < 20) begin @(negedge clk); g++; end
    chk("first_ready_lat", cyc - c0, 5);

    for (int i = 0; i < n; i++) begin
      gaps = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 3)) : 0);
      for (int j = 0; j < gaps; j++) begin s_valid = 1'b0; @(negedge clk); end
      s_valid = 1'b1; s_data = bytes_q[i]; s_last = (i == n - 1);
      if (poke_start && i == 1) start = 1'b1;
      g = 0;
      while (!s_ready && g < 50) begin @(negedge clk); g++; end
      if (g >= 50) stuck = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("stream_stall", stuck, 0);

    g = 0;
    while (!done && g < 40) begin @(negedge clk); g++; end
    chk("done_seen", done, 1);
    done_at = cyc;
    chk("crc_result", crc_result, rdv);
    chk("busy_after", busy, 0);
    chk("done_lat", done_at - last_wr_cyc, 2);

    // Reference: bytes grouped in fours, first byte most significant
    nw   = (n + 3) / 4;
    npad = (4 - n % 4) % 4;
    chk("word_count", word_count, (nw > WC_MAX) ? WC_MAX : nw);
    chk("pad_bytes", pad_bytes, npad);
    chk("timeout_err", timeout_err, 0);
    chk("bus_len", bus_log.size() - lb, 5 + nw);
    if (bus_log.size() == lb + 5 + nw) begin
      chk("wr_ctrl_s", bus_log[lb],     {BASE + 32'd8, ctrl | WAS, 1'b1});
      chk("wr_seed",   bus_log[lb + 1], {BASE, seed, 1'b1});
      chk("wr_poly",   bus_log[lb + 2], {BASE + 32'd4, poly, 1'b1});
      chk("wr_ctrl_r", bus_log[lb + 3], {BASE + 32'd8, ctrl & ~WAS, 1'b1});
      for (int wi = 0; wi < nw; wi++) begin
        w = 32'h0;
        for (int b = 0; b < 4; b++)
          if (4 * wi + b < n) w = w | (32'(bytes_q[4 * wi + b]) << (24 - 8 * b));
        chk("wr_data", bus_log[lb + 4 + wi], {BASE, w, 1'b1});
      end
      e = bus_log[lb + 4 + nw];
      chk("rd_res", {e[64:33], e[0]}, {BASE, 1'b0});
    end

    @(negedge clk);
    chk("done_pulse_width", done, 0);
    chk("done_count", done_cnt - db, 1);
    chk("ready_in_wr_data", rdy_in_wr - rb, 0);
    $display("job bytes=%0d words=%0d pad=%0d crc=%h", n, nw, npad, crc_result);
  endtask

  initial begin
    int g, db, lb;
    rst = 1'b1; start = 1'b0;
    cfg_ctrl = 32'h0; cfg_poly = 32'h0; cfg_seed = 32'h0; data_rd = 32'h0;
    s_data = 8'h0; s_valid = 1'b0; s_last = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_data_wr", data_wr, 0);
    chk("rst_rw", RW, 0);
    chk("rst_sel", Sel, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_crc", crc_result, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_pad", pad_bytes, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_sel", Sel, 0);
    $display("reset released");

    // Register sequence plus a single full word
    fill_seq(8'h31, 4);
    run_job(32'h0000_0000, 32'h0000_1021, 32'h0000_FFFF, 32'h0000_ABCD, 0, 1'b0);

    // Padding of the last word
    fill_seq(8'h31, 9);
    run_job($urandom, $urandom, $urandom, $urandom, 0, 1'b0);

    // Backpressure: s_valid toggling
    fill_rand(11);
    run_job($urandom, $urandom, $urandom, $urandom, 1, 1'b0);

    // start pulsed mid-stream must be ignored
    fill_rand(7);
    run_job($urandom, $urandom, $urandom, $urandom, 0, 1'b1);

    // word_count saturation (5 writes, count held at all-ones)
    fill_rand(20);
    run_job($urandom, $urandom, $urandom, $urandom, 2, 1'b0);

    // Reset during the stream, while a DATA write is on the bus
    db = done_cnt;
    @(negedge clk);
    cfg_ctrl = $urandom; cfg_poly = $urandom; cfg_seed = $urandom;
    data_rd = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!s_ready && g < 20) begin @(negedge clk); g++; end
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    chk("pre_rst_sel", Sel, 1);
    rst = 1'b1;
    #1;
    chk("midrst_sel", Sel, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_s_ready", s_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_crc", crc_result, 0);
    chk("midrst_word_count", word_count, 0);
    chk("midrst_no_done", done_cnt - db, 0);
    chk("midrst_idle_busy", busy, 0);
    $display("mid-job reset done");

`ifdef CRC_FEEDER_TIMEOUT_EN
    // Stall abort: two bytes, then s_valid held low
    lb = bus_log.size(); db = done_cnt;
    @(negedge clk);
    cfg_ctrl = $urandom; cfg_poly = $urandom; cfg_seed = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    g = 0;
    while (!s_ready && g < 20) begin @(negedge clk); g++; end
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1; s_data = 8'($urandom); s_last = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b0;
    g = 0;
    while (busy && g < 40) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    chk("to_err", timeout_err, 1);
    chk("to_busy", busy, 0);
    chk("to_bus_len", bus_log.size() - lb, 4);
    chk("to_no_done", done_cnt - db, 0);
    $display("timeout job done err=%0d", timeout_err);
`else
    lb = 0;
`endif

    // Randomized jobs
    for (int k = 0; k < 6; k++) begin
      fill_rand($urandom_range(1, 12));
      run_job($urandom, $urandom, $urandom, $urandom, 2, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
